// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and types for the RISC-V front end.
// Defining FETCH_MISALIGN_TRAP_EN adds the HALT fetch state used by the misaligned-target trap.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instruction field slices used by the decoder downstream of fetch.
  localparam int unsigned OP_LSB       = 0;
  localparam int unsigned OP_MSB       = 6;
  localparam int unsigned FUNCT3_LSB   = 12;
  localparam int unsigned FUNCT3_MSB   = 14;
  localparam int unsigned FUNCT7B5_BIT = 30;

  typedef enum logic [2:0] {
    FETCH_IDLE    = 3'd0,
    FETCH_REQ     = 3'd1,
    FETCH_HOLD    = 3'd2,
    FETCH_DISCARD = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
    , FETCH_HALT  = 3'd4
`endif
  } fetch_state_t;

endpackage

// File: rtl/instr_hold_reg.sv
// Instruction holding register: loads fetched data, holds it, and clears back to a NOP.
// A cleared register always reads NOP_INSTR so decode sees a no-op when nothing is valid.
module instr_hold_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic        r_valid;

  // Clear wins over load so a flush in the same cycle as returning data drops it.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: PC register, fetch FSM and memory handshake.
// Defining FETCH_MISALIGN_TRAP_EN traps misaligned branch targets into HALT and drives MisalignErr.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] FlushPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignErr
);

  // imem handshake: imem_req stays high with a stable imem_addr until the cycle imem_rvalid
  // is seen (rvalid may coincide with the first req cycle); only one request is ever in
  // flight, and an rvalid arriving outside REQ belongs to an abandoned request and is dropped.

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic [31:0]  w_flush_pc;
  logic         w_load;
  logic         w_clear;
  logic         w_unused_lsbs;

  assign w_flush_pc = {FlushPC[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_trap;

  // Raw target so a misaligned one can be detected and trapped.
  assign w_target      = PCTarget;
  assign w_unused_lsbs = ^FlushPC[1:0];
`else
  assign w_target      = {PCTarget[31:2], 2'b00};
  assign w_unused_lsbs = ^{PCTarget[1:0], FlushPC[1:0]};
`endif

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_clear      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_trap       = 1'b0;
`endif
    if (flush) begin
      w_pc_next = w_flush_pc;
      w_clear   = 1'b1;
      case (r_state)
        // A response arriving with the flush retires the outstanding request.
        FETCH_REQ, FETCH_DISCARD: w_state_next = imem_rvalid ? FETCH_REQ : FETCH_DISCARD;
        default:                  w_state_next = FETCH_REQ;
      endcase
    end else begin
      case (r_state)
        FETCH_IDLE: w_state_next = FETCH_REQ;
        FETCH_REQ: begin
          if (imem_rvalid) begin
            w_load       = 1'b1;
            w_state_next = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            w_clear      = 1'b1;
            w_state_next = FETCH_REQ;
            if (PCSrc) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              if (w_target[1:0] != 2'b00) begin
                w_trap       = 1'b1;
                w_state_next = FETCH_HALT;
              end else begin
                w_pc_next = w_target;
              end
`else
              w_pc_next = w_target;
`endif
            end else begin
              w_pc_next = w_pc_plus4;
            end
          end
        end
        FETCH_DISCARD: begin
          if (imem_rvalid) w_state_next = FETCH_REQ;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset || flush) r_misalign <= 1'b0;
    else if (w_trap)    r_misalign <= 1'b1;
  end

  assign MisalignErr = r_misalign;
`else
  assign MisalignErr = 1'b0;
`endif

  instr_hold_reg u_instr_hold_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_data  (imem_rdata),
    .o_instr (Instr),
    .o_valid (InstrValid)
  );

  assign imem_req  = (r_state == FETCH_REQ);
  assign imem_addr = {r_pc[31:2], 2'b00};
  assign PC        = r_pc;
  assign PCPlus4   = w_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, fetch latency, stall, retire, flush, wrap.
// The misaligned-trap scenario is exercised when FETCH_MISALIGN_TRAP_EN is defined.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] FlushPC = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignErr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .stall       (stall),
    .flush       (flush),
    .FlushPC     (FlushPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .InstrValid  (InstrValid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .MisalignErr (MisalignErr)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0003);
  endfunction

  // Wait for a request, check its address against the queue, answer after lat cycles.
  task automatic serve(input int lat);
    logic [31:0] exp_a;
    int guard;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    exp_a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("imem_addr", imem_addr, exp_a);
    repeat (lat) @(negedge clk);
    check("req_held", {31'b0, imem_req}, 32'd1);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(exp_a);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    check("hold_instr", Instr, mem_word(exp_a));
    check("hold_valid", {31'b0, InstrValid}, 32'd1);
    check("hold_pc", PC, exp_a);
    check("hold_pcplus4", PCPlus4, exp_a + 32'd4);
    check("hold_req_low", {31'b0, imem_req}, 32'd0);
  endtask

  // Release the held instruction with the given redirect and queue the next fetch address.
  task automatic retire(input logic src, input logic [31:0] tgt, input logic [31:0] next_addr);
    PCSrc    = src;
    PCTarget = tgt;
    stall    = 1'b0;
    @(negedge clk);
    PCSrc    = 1'b0;
    PCTarget = 32'hFFFF_FFFF;
    check("retire_valid", {31'b0, InstrValid}, 32'd0);
    check("retire_nop", Instr, NOP);
    exp_q.push_back(next_addr);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, InstrValid}, 32'd0);
    check("rst_instr", Instr, NOP);
    check("rst_pc", PC, 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h4);
    check("rst_misalign", {31'b0, MisalignErr}, 32'd0);

    // Stale rvalid in the first IDLE cycle must be ignored
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0000;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("stale_valid", {31'b0, InstrValid}, 32'd0);
    check("stale_instr", Instr, NOP);

    // First fetch, 1-cycle memory
    exp_q.push_back(32'h0);
    serve(1);
    check("op_field", {25'b0, Instr[6:0]}, 32'h13);

    // Stall holds everything; PCSrc/PCTarget ignored outside retire
    stall    = 1'b1;
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_instr", Instr, 32'h0050_0093);
      check("stall_pc", PC, 32'h0);
      check("stall_valid", {31'b0, InstrValid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end

    // Sequential and branch retires
    retire(1'b0, 32'h0, 32'h4);
    serve(2);
    retire(1'b0, 32'h0, 32'h8);
    serve(0);
    retire(1'b0, 32'h1234_5678, 32'hC);
    serve(1);
    retire(1'b1, 32'h100, 32'h100);
    serve(3);

    // Flush in REQ, response 2 cycles later is dropped
    retire(1'b0, 32'h0, 32'h104);
    check("req_104", imem_addr, exp_q.pop_front());
    flush   = 1'b1;
    FlushPC = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    check("discard_req", {31'b0, imem_req}, 32'd0);
    check("discard_pc", PC, 32'h200);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_CAFE;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("drop_valid", {31'b0, InstrValid}, 32'd0);
    check("drop_instr", Instr, NOP);
    exp_q.push_back(32'h200);
    serve(1);

    // Flush in REQ with rvalid the same cycle
    retire(1'b0, 32'h0, 32'h204);
    check("req_204", imem_addr, exp_q.pop_front());
    flush       = 1'b1;
    FlushPC     = 32'h300;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_BEEF;
    @(negedge clk);
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    check("flush_rv_valid", {31'b0, InstrValid}, 32'd0);
    check("flush_rv_instr", Instr, NOP);
    exp_q.push_back(32'h300);
    serve(0);

    // Flush in HOLD beats stall; low FlushPC bits forced to zero
    stall   = 1'b1;
    flush   = 1'b1;
    FlushPC = 32'h403;
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    check("flush_hold_valid", {31'b0, InstrValid}, 32'd0);
    exp_q.push_back(32'h400);
    serve(2);

    // PC wrap at the top of the address space
    flush   = 1'b1;
    FlushPC = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    serve(1);
    check("wrap_pcplus4", PCPlus4, 32'h0);
    retire(1'b0, 32'h0, 32'h0);
    serve(0);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned branch target traps into HALT
    PCSrc    = 1'b1;
    PCTarget = 32'h102;
    @(negedge clk);
    PCSrc = 1'b0;
    check("trap_misalign", {31'b0, MisalignErr}, 32'd1);
    check("trap_req", {31'b0, imem_req}, 32'd0);
    check("trap_pc", PC, 32'h0);
    check("trap_valid", {31'b0, InstrValid}, 32'd0);
    repeat (2) @(negedge clk);
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_sticky", {31'b0, MisalignErr}, 32'd1);
    flush   = 1'b1;
    FlushPC = 32'h40;
    @(negedge clk);
    flush = 1'b0;
    check("halt_exit_misalign", {31'b0, MisalignErr}, 32'd0);
    exp_q.push_back(32'h40);
    serve(1);
`else
    // Low target bits are forced to zero without the trap
    retire(1'b1, 32'h102, 32'h100);
    check("no_trap_misalign", {31'b0, MisalignErr}, 32'd0);
    serve(1);
`endif

    // Reset mid-request abandons it; stale rvalid after reset ignored
    flush   = 1'b1;
    FlushPC = 32'h600;
    @(negedge clk);
    flush = 1'b0;
    exp_q.push_back(32'h600);
    check("req_600", imem_addr, exp_q.pop_front());
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_pc", PC, 32'h0);
    check("midrst_valid", {31'b0, InstrValid}, 32'd0);
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0600;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("midrst_stale_valid", {31'b0, InstrValid}, 32'd0);
    exp_q.push_back(32'h0);
    serve(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC loaded at reset.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- PCSrc  in  1  from controller: take branch/jump target at retire
- PCTarget  in  32  branch/jump target address
- stall  in  1  downstream not ready; hold current instruction
- flush  in  1  redirect fetch to FlushPC, discard in-flight work
- FlushPC  in  32  redirect address
- imem_req  out  1  instruction memory read request
- imem_addr  out  32  word address of request (equals PC)
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- Instr  out  32  instruction to decode (op = Instr[6:0], funct3 = Instr[14:12], funct7b5 = Instr[30])
- InstrValid  out  1  Instr holds a fetched instruction
- PC  out  32  address of Instr
- PCPlus4  out  32  PC + 4
- MisalignErr  out  1  misaligned target trap (FETCH_MISALIGN_TRAP_EN only; tied 0 otherwise)

Function
REQ-004 States SHALL be IDLE, REQ, HOLD, DISCARD, plus HALT when FETCH_MISALIGN_TRAP_EN is defined.
REQ-005 IDLE: imem_req=0; next state REQ unconditionally.
REQ-006 REQ: imem_req=1, imem_addr=PC, held until imem_rvalid; on rvalid, Instr<=imem_rdata and next state HOLD.
REQ-007 Memory latency SHALL be tolerated as any N>=0 cycles after imem_req rises; at most one request outstanding.
REQ-008 HOLD: InstrValid=1, imem_req=0; while stall=1, Instr and PC SHALL be stable.
REQ-009 Retire = HOLD & !stall & !flush: PC<=(PCSrc ? PCTarget : PCPlus4), InstrValid<=0, next state REQ.
REQ-010 When InstrValid=0, Instr SHALL read NOP_INSTR (32'h0000_0013) so the controller decodes a no-op.
REQ-011 PCSrc and PCTarget SHALL be ignored outside a retire cycle.
REQ-012 PCPlus4 SHALL be combinational PC+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-013 flush SHALL take priority over retire and stall, loading PC<=FlushPC in every state.
REQ-014 flush in IDLE or HOLD: InstrValid<=0, next state REQ.
REQ-015 flush in REQ without imem_rvalid: next state DISCARD; with imem_rvalid the same cycle: data dropped, next state REQ.
REQ-016 DISCARD: imem_req=0; the next imem_rvalid SHALL be dropped, then REQ; a further flush updates PC and stays in DISCARD.
REQ-017 imem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-018 On reset: PC=RESET_VECTOR, state IDLE, InstrValid=0, Instr=NOP_INSTR, imem_req=0, MisalignErr=0.
REQ-019 Reset asserted mid-request SHALL abandon it; a stale rvalid in the first IDLE cycle after reset SHALL be ignored.

Configuration
REQ-020 With FETCH_MISALIGN_TRAP_EN defined: a retire with PCSrc=1 and PCTarget[1:0]!=0 SHALL leave PC unchanged, set MisalignErr=1 (sticky), and enter HALT (no requests); only flush or reset leaves HALT, and both clear MisalignErr.
REQ-021 Without FETCH_MISALIGN_TRAP_EN: PCTarget[1:0] and FlushPC[1:0] SHALL be forced to 2'b00, there is no HALT state, and MisalignErr SHALL be constant 0.

Structure
REQ-022 riscv_pkg SHALL hold NOP_INSTR, the fetch state enum type, and the instruction field slice constants.
REQ-023 Sub-module instr_hold_reg SHALL own the Instr/InstrValid register (load, hold, clear-to-NOP); PC and FSM stay in fetch_unit.

Verification
REQ-024 Reset release with a 1-cycle memory returning 0x00500093 -> imem_addr=0x0, then Instr=0x00500093 with InstrValid=1 and PC=0x0.
REQ-025 Retire with PCSrc=0 at PC=0x8 -> next imem_addr=0xC; retire with PCSrc=1 and PCTarget=0x100 -> next imem_addr=0x100.
REQ-026 stall=1 for 3 cycles in HOLD -> Instr, PC, and InstrValid unchanged, imem_req=0.
REQ-027 flush with FlushPC=0x200 in REQ, rvalid 2 cycles later -> that data is dropped and the next imem_addr=0x200.
REQ-028 Retire at PC=0xFFFF_FFFC with PCSrc=0 -> imem_addr=0x0.
REQ-029 With FETCH_MISALIGN_TRAP_EN, retire with PCSrc=1 and PCTarget=0x102 -> MisalignErr=1, imem_req stays 0; flush with FlushPC=0x40 -> MisalignErr=0 and imem_addr=0x40.
